// File: rtl/dac_sched_pkg.sv
// rtl/dac_sched_pkg.sv - shared state enum, frame layout and channel codes for dac_scheduler
package dac_sched_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, CS_HOLD} state_t;

  localparam int BIT_CH     = 15;
  localparam int BIT_BUF    = 14;
  localparam int BIT_GA_N   = 13;
  localparam int BIT_SHDN_N = 12;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  // Output buffer is always bypassed and the channel is never shut down.
  function automatic logic [15:0] make_frame(input logic ch, input logic gain1,
                                             input logic [11:0] code);
    logic [15:0] f;
    f             = {4'b0000, code};
    f[BIT_CH]     = ch;
    f[BIT_BUF]    = 1'b0;
    f[BIT_GA_N]   = gain1;
    f[BIT_SHDN_N] = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/spi_dac_tx.sv
// rtl/spi_dac_tx.sv - 16-bit SPI frame serializer driving CS/SCLK/SDO with CS-high hold time
module spi_dac_tx
  import dac_sched_pkg::*;
#(
  parameter int T_HALF = 1,
  parameter int T_CSH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        start,
  input  logic [15:0] frame,
  output logic        done,
  output logic        busy,
  output logic        CS,
  output logic        SCLK,
  output logic        SDO
);

  localparam logic [3:0] HALF_LAST = 4'(T_HALF - 1);
  localparam logic [3:0] CSH_LAST  = 4'(T_CSH - 1);

  state_t      state;
  logic [3:0]  dly;
  logic [3:0]  nbit;
  logic [15:0] sreg;

  assign SDO  = sreg[15];
  assign busy = (state != IDLE);
  // High during the cycle whose closing edge ends the 16th SCLK-high phase.
  assign done = enable && (state == SHIFT_HI) && (dly == HALF_LAST) && (nbit == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      CS    <= 1'b1;
      SCLK  <= 1'b0;
      sreg  <= '0;
      dly   <= '0;
      nbit  <= '0;
    end else if (!enable && (state == SHIFT_LO || state == SHIFT_HI)) begin
      state <= CS_HOLD;
      CS    <= 1'b1;
      SCLK  <= 1'b0;
      dly   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT_LO;
            CS    <= 1'b0;
            sreg  <= frame;
            dly   <= '0;
            nbit  <= '0;
          end
        end
        SHIFT_LO: begin
          if (dly == HALF_LAST) begin
            SCLK  <= 1'b1;
            state <= SHIFT_HI;
            dly   <= '0;
          end else begin
            dly <= dly + 4'd1;
          end
        end
        SHIFT_HI: begin
          if (dly == HALF_LAST) begin
            SCLK <= 1'b0;
            dly  <= '0;
            if (nbit == 4'd15) begin
              CS    <= 1'b1;
              state <= CS_HOLD;
            end else begin
              sreg  <= {sreg[14:0], 1'b0};
              nbit  <= nbit + 4'd1;
              state <= SHIFT_LO;
            end
          end else begin
            dly <= dly + 4'd1;
          end
        end
        CS_HOLD: begin
          if (dly == CSH_LAST) begin
            state <= IDLE;
            dly   <= '0;
          end else begin
            dly <= dly + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dac_scheduler.sv
// rtl/dac_scheduler.sv - round-robin two-channel DAC update scheduler; DAC_SCHED_LDAC_EN adds LDAC_n strobe
module dac_scheduler
  import dac_sched_pkg::*;
#(
  parameter int T_HALF = 1,
  parameter int T_CSH  = 2,
  parameter int GAIN1  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [11:0] data_a,
  input  logic [11:0] data_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic        busy,
  output logic        CS,
  output logic        SCLK,
  output logic        SDO
`ifdef DAC_SCHED_LDAC_EN
  ,
  output logic        LDAC_n
`endif
);

  logic        grant;
  logic        grant_b;
  logic        last_b;
  logic [15:0] frame;

  // last_b also names the channel of the frame in flight, since it only moves on a grant.
  assign grant   = enable && !busy && (req_a || req_b);
  assign grant_b = req_b && (!req_a || !last_b);
  assign frame   = make_frame(grant_b ? CH_B : CH_A, GAIN1 != 0, grant_b ? data_b : data_a);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_a  <= 1'b0;
      ack_b  <= 1'b0;
      last_b <= 1'b1;
    end else begin
      ack_a <= grant && !grant_b;
      ack_b <= grant && grant_b;
      if (grant) begin
        last_b <= grant_b;
      end
    end
  end

`ifdef DAC_SCHED_LDAC_EN
  logic done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      LDAC_n <= 1'b1;
    end else begin
      LDAC_n <= !(done && last_b);
    end
  end
`endif

  spi_dac_tx #(
    .T_HALF (T_HALF),
    .T_CSH  (T_CSH)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .start  (grant),
    .frame  (frame),
`ifdef DAC_SCHED_LDAC_EN
    .done   (done),
`else
    .done   (),
`endif
    .busy   (busy),
    .CS     (CS),
    .SCLK   (SCLK),
    .SDO    (SDO)
  );

endmodule

// File: tb/tb_dac_scheduler.sv
// tb/tb_dac_scheduler.sv - scoreboard bench for dac_scheduler (T_HALF=1 and T_HALF=3 instances)
module tb_dac_scheduler;

  logic        clk = 1'b0;
  logic        rst, enable, req_a, req_b;
  logic [11:0] data_a, data_b;
  logic        ack_a, ack_b, busy, cs, sclk, sdo;
  logic        enable3, req3_a, req3_b;
  logic [11:0] data3_a, data3_b;
  logic        ack3_a, ack3_b, busy3, cs3, sclk3, sdo3;
`ifdef DAC_SCHED_LDAC_EN
  logic        ldac_n, ldac3_n;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] cap_q[$];
  int          len_q[$];
  int          gap_q[$];
  int          ldac_low_cnt = 0;
  int          ldac_bad     = 0;

  always #5 clk = ~clk;

  dac_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b), .ack_a(ack_a), .ack_b(ack_b), .busy(busy),
    .CS(cs), .SCLK(sclk), .SDO(sdo)
`ifdef DAC_SCHED_LDAC_EN
    , .LDAC_n(ldac_n)
`endif
  );

  dac_scheduler #(.T_HALF(3)) dut3 (
    .clk(clk), .rst(rst), .enable(enable3), .req_a(req3_a), .req_b(req3_b),
    .data_a(data3_a), .data_b(data3_b), .ack_a(ack3_a), .ack_b(ack3_b), .busy(busy3),
    .CS(cs3), .SCLK(sclk3), .SDO(sdo3)
`ifdef DAC_SCHED_LDAC_EN
    , .LDAC_n(ldac3_n)
`endif
  );

  // Frame monitor on the T_HALF=1 instance: captures completed frames, CS-low lengths and CS-high gaps.
  initial begin
    logic        prev_cs, prev_sclk, last_ch;
    logic [15:0] sh;
    int          nbits, low_len, hi_run;
    prev_cs = 1'b1; prev_sclk = 1'b0; last_ch = 1'b0; sh = '0;
    nbits = 0; low_len = 0; hi_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_cs = 1'b1; prev_sclk = 1'b0; last_ch = 1'b0;
        nbits = 0; low_len = 0; hi_run = 0;
      end else begin
        if (cs === 1'b0) begin
          if (prev_cs) begin
            gap_q.push_back(hi_run);
            nbits = 0;
            low_len = 0;
          end
          low_len++;
          if (sclk === 1'b1 && !prev_sclk) begin
            sh = {sh[14:0], sdo};
            nbits++;
          end
          hi_run = 0;
        end else begin
          if (!prev_cs) begin
            if (nbits == 16) begin
              cap_q.push_back(sh);
              len_q.push_back(low_len);
              last_ch = sh[15];
            end else begin
              last_ch = 1'b0;
            end
          end
          hi_run++;
        end
`ifdef DAC_SCHED_LDAC_EN
        if (ldac_n === 1'b0) begin
          ldac_low_cnt++;
          if (!(cs === 1'b1 && hi_run == 1 && last_ch)) ldac_bad++;
        end
`endif
        prev_cs = cs;
        prev_sclk = sclk;
      end
    end
  end

  task automatic wait_ack(output logic got_a, output logic got_b, output bit ok);
    ok = 0; got_a = 0; got_b = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ack_a === 1'b1 || ack_b === 1'b1) begin
        ok = 1; got_a = ack_a; got_b = ack_b;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (cs !== 1'b1)    begin bad++; $display("FAIL reset_cs got=%b exp=1", cs); end
    total++; if (sclk !== 1'b0)  begin bad++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
    total++; if (sdo !== 1'b0)   begin bad++; $display("FAIL reset_sdo got=%b exp=0", sdo); end
    total++; if ({ack_a, ack_b} !== 2'b00) begin bad++; $display("FAIL reset_ack got=%b%b exp=00", ack_a, ack_b); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (cs3 !== 1'b1)   begin bad++; $display("FAIL reset_cs3 got=%b exp=1", cs3); end
`ifdef DAC_SCHED_LDAC_EN
    total++; if (ldac_n !== 1'b1) begin bad++; $display("FAIL reset_ldac got=%b exp=1", ldac_n); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic a, b; bit ok;
    data_a = 12'h123; req_a = 1'b1;
    exp_q.push_back(16'h3123);
    wait_ack(a, b, ok);
    req_a = 1'b0;
    total++; if (!ok || {a, b} !== 2'b10) begin bad++; $display("FAIL single_ack got=%b%b ok=%0d exp=10", a, b, ok); end
    total++; if (cs !== 1'b0)   begin bad++; $display("FAIL single_cs_with_ack got=%b exp=0", cs); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    @(negedge clk);
    total++; if (ack_a !== 1'b0) begin bad++; $display("FAIL single_ack_pulse got=%b exp=0", ack_a); end
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL single_idle_timeout got=busy exp=idle"); end
  endtask

  task automatic test_round_robin();
    logic a, b; bit ok; int n0, l0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    n0 = gap_q.size(); l0 = ldac_low_cnt;
    data_a = 12'h0AA; data_b = 12'h555; req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back((i % 2 == 0) ? 16'h30AA : 16'hB555);
      wait_ack(a, b, ok);
      total++;
      if (!ok || b !== logic'(i % 2) || a !== logic'(1 - i % 2)) begin
        bad++; $display("FAIL rr_grant%0d got=a%b b%b ok=%0d exp_b=%0d", i, a, b, ok, i % 2);
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    wait_idle(ok);
    for (int i = 1; i < 4; i++) begin
      total++;
      if (gap_q.size() < n0 + 4) begin
        bad++; $display("FAIL rr_gap%0d got=missing exp=3", i);
      end else if (gap_q[n0 + i] != 3) begin
        bad++; $display("FAIL rr_gap%0d got=%0d exp=3", i, gap_q[n0 + i]);
      end
    end
`ifdef DAC_SCHED_LDAC_EN
    total++; if (ldac_low_cnt - l0 != 2) begin bad++; $display("FAIL rr_ldac_pulses got=%0d exp=2", ldac_low_cnt - l0); end
    total++; if (ldac_bad != 0) begin bad++; $display("FAIL ldac_placement got=%0d exp=0", ldac_bad); end
`else
    total++; if (ldac_low_cnt != l0) begin bad++; $display("FAIL rr_ldac_pulses got=%0d exp=%0d", ldac_low_cnt, l0); end
`endif
  endtask

  task automatic test_abort();
    logic a, b, prev; bit ok; int rises, acks;
    data_a = 12'h456; req_a = 1'b1;
    wait_ack(a, b, ok);
    req_a = 1'b0;
    data_b = 12'h789; req_b = 1'b1;
    rises = 0; prev = sclk;
    for (int i = 0; i < 100 && rises < 8; i++) begin
      @(negedge clk);
      if (sclk === 1'b1 && !prev) rises++;
      prev = sclk;
    end
    enable = 1'b0;
    @(negedge clk);
    total++; if (cs !== 1'b1 || sclk !== 1'b0) begin bad++; $display("FAIL abort_lines got=cs%b sclk%b exp=cs1 sclk0", cs, sclk); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_hold_busy got=%b exp=1", busy); end
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack_a === 1'b1 || ack_b === 1'b1) acks++;
    end
    total++; if (acks != 0) begin bad++; $display("FAIL abort_no_ack got=%0d exp=0", acks); end
    enable = 1'b1;
    exp_q.push_back(16'hB789);
    wait_ack(a, b, ok);
    req_b = 1'b0;
    total++; if (!ok || {a, b} !== 2'b01) begin bad++; $display("FAIL abort_regrant got=%b%b ok=%0d exp=01", a, b, ok); end
    wait_idle(ok);
  endtask

  task automatic test_reset_mid_frame();
    logic a, b; bit ok;
    data_b = 12'h2F0; req_b = 1'b1;
    wait_ack(a, b, ok);
    req_b = 1'b0;
    total++; if (!ok || {a, b} !== 2'b01) begin bad++; $display("FAIL rstmid_first got=%b%b exp=01", a, b); end
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (cs !== 1'b1 || sclk !== 1'b0 || sdo !== 1'b0) begin
      bad++; $display("FAIL rstmid_async got=cs%b sclk%b sdo%b exp=cs1 sclk0 sdo0", cs, sclk, sdo);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    @(negedge clk);
    data_a = 12'h00F; data_b = 12'hFFF; req_a = 1'b1; req_b = 1'b1;
    rst = 1'b0;
    exp_q.push_back(16'h300F);
    wait_ack(a, b, ok);
    req_a = 1'b0; req_b = 1'b0;
    total++; if (!ok || {a, b} !== 2'b10) begin bad++; $display("FAIL rstmid_rr_ptr got=%b%b exp=10", a, b); end
    wait_idle(ok);
  endtask

  task automatic test_t_half3();
    bit ok; logic prev; logic [15:0] sh; int low, run, runs_bad, nruns, ackb;
    data3_a = 12'hABC; req3_a = 1'b1;
    ok = 0; ackb = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack3_b === 1'b1) ackb++;
      if (ack3_a === 1'b1) begin ok = 1; break; end
    end
    req3_a = 1'b0;
    total++; if (!ok || ackb != 0) begin bad++; $display("FAIL th3_ack got=ok%0d ackb%0d exp=ok1 ackb0", ok, ackb); end
    low = 0; run = 0; runs_bad = 0; nruns = 0; sh = '0; prev = sclk3;
    for (int i = 0; i < 400 && cs3 === 1'b0; i++) begin
      if (sclk3 !== prev) begin
        if (run != 3) runs_bad++;
        nruns++; run = 0;
        if (sclk3 === 1'b1) sh = {sh[14:0], sdo3};
      end
      run++; low++; prev = sclk3;
      @(negedge clk);
    end
    if (run != 3) runs_bad++;
    nruns++;
    total++; if (low != 96) begin bad++; $display("FAIL th3_cs_low got=%0d exp=96", low); end
    total++; if (runs_bad != 0 || nruns != 32) begin bad++; $display("FAIL th3_phases got=bad%0d n%0d exp=bad0 n32", runs_bad, nruns); end
    total++; if (sh !== 16'h3ABC) begin bad++; $display("FAIL th3_frame got=%h exp=3abc", sh); end
    total++; if (busy3 !== 1'b1) begin bad++; $display("FAIL th3_hold_busy got=%b exp=1", busy3); end
`ifdef DAC_SCHED_LDAC_EN
    total++; if (ldac3_n !== 1'b1) begin bad++; $display("FAIL th3_ldac_after_a got=%b exp=1", ldac3_n); end
`endif
  endtask

  task automatic test_frames();
    logic [15:0] e, g; int len;
    for (int i = 0; i < 200 && cap_q.size() < exp_q.size(); i++) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (cap_q.size() == 0) begin
        bad++; $display("FAIL frame got=none exp=%h", e);
      end else begin
        g = cap_q.pop_front();
        len = len_q.pop_front();
        if (g !== e) begin bad++; $display("FAIL frame got=%h exp=%h", g, e); end
        total++;
        if (len != 32) begin bad++; $display("FAIL frame_cs_low got=%0d exp=32 frame=%h", len, e); end
      end
    end
    total++; if (cap_q.size() != 0) begin bad++; $display("FAIL frame_extra got=%0d exp=0", cap_q.size()); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0;
    enable3 = 1'b1; req3_a = 1'b0; req3_b = 1'b0; data3_a = '0; data3_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_reset_mid_frame();
    test_t_half3();
    test_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac_scheduler.md
DAC_SCHEDULER -- requirements
Module: dac_scheduler

Interface
REQ-001 SHALL have parameter T_HALF, default 1: SCLK half-period in clk cycles, legal range 1..15.
REQ-002 SHALL have parameter T_CSH, default 2: minimum CS-high time between frames in clk cycles, legal range 1..15.
REQ-003 SHALL have parameter GAIN1, default 1: value placed in frame bit 13 (GA_n); 1 = 1x gain, 0 = 2x gain.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1 bit: synchronous run enable.
REQ-007 SHALL have ports req_a and req_b, input, 1 bit each: channel A/B update request.
REQ-008 SHALL have ports data_a and data_b, input, 12 bits each: channel code.
REQ-009 SHALL have ports ack_a and ack_b, output, 1 bit each: one-cycle acceptance pulse.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have ports CS, SCLK and SDO, output, 1 bit each: SPI link to the DAC.

Function
REQ-012 SHALL implement states IDLE, SHIFT_LO, SHIFT_HI and CS_HOLD.
REQ-013 Requester handshake SHALL be: hold req high and data stable until ack; data is sampled on the cycle ack is high.
REQ-014 In IDLE with enable=1 and at least one req high, SHALL grant one channel, pulse its ack for one cycle, latch the frame, drive CS low and enter SHIFT_LO, all on the same edge.
REQ-015 Arbitration SHALL be round-robin: when both req are high, the channel not granted last wins; a lone request is granted immediately.
REQ-016 Frame SHALL be {ch, 1'b0 BUF, GAIN1, 1'b1 SHDN_n, data[11:0]}, with ch=0 for A and ch=1 for B; with GAIN1=1, A gives 0x3000|data and B gives 0xB000|data.
REQ-017 SDO SHALL equal the frame MSB, shifting left one bit on each SCLK falling edge.
REQ-018 SHIFT_LO SHALL hold SCLK=0 for T_HALF cycles, then set SCLK=1 and enter SHIFT_HI.
REQ-019 SHIFT_HI SHALL hold SCLK=1 for T_HALF cycles, then:
- after rising edges 1..15: SCLK=0, shift, enter SHIFT_LO;
- after rising edge 16: SCLK=0, CS=1, enter CS_HOLD.
REQ-020 CS SHALL stay low for exactly 32*T_HALF cycles per frame.
REQ-021 CS_HOLD SHALL last T_CSH cycles, then enter IDLE; requests are not granted during CS_HOLD.
REQ-022 A request arriving mid-frame SHALL wait without loss; back-to-back frames SHALL be separated by T_CSH+1 cycles of CS high.
REQ-023 enable=0 SHALL abort any frame on the next edge: CS=1, SCLK=0, go to CS_HOLD; no ack is issued while enable=0.
REQ-024 A request dropped before ack SHALL be forgotten.

Reset
REQ-025 While rst is high, SHALL force: state IDLE, CS=1, SCLK=0, SDO=0, ack_a=ack_b=0, busy=0, shift register 0, round-robin pointer favouring A.

Configuration
REQ-026 With DAC_SCHED_LDAC_EN defined, SHALL add output LDAC_n (reset 1), driven low for exactly one cycle on the first CS_HOLD cycle following a channel-B frame, so that A-then-B updates latch together.
REQ-027 Without DAC_SCHED_LDAC_EN, the LDAC_n port and its logic SHALL be absent; the DAC's LDAC pin is tied low on the board.

Structure
REQ-028 Package dac_sched_pkg SHALL hold the state enum, the frame bit positions (CH=15, BUF=14, GA_n=13, SHDN_n=12) and the channel-select constants.
REQ-029 The serializer (CS/SCLK/SDO generation, bit counter and delay counter) SHALL be sub-module spi_dac_tx, with frame/start inputs and a done output; dac_scheduler contains the arbiter and handshake.

Verification
REQ-030 With T_HALF=1, req_a=1 and data_a=0x123: ack_a pulses on the same cycle CS falls; SDO carries 0x3123 MSB first, sampled on 16 SCLK rising edges; CS is low for 32 cycles.
REQ-031 With req_a and req_b both high from reset: grants go A, B, A, B; SDO frames are 0x3xxx, 0xBxxx alternately; each gap is 3 CS-high cycles.
REQ-032 With T_HALF=3: each SCLK phase lasts 3 cycles and CS is low for 96 cycles.
REQ-033 Drop enable at the 8th rising edge: CS rises on the next edge and SCLK is 0; after enable returns, the pending req is re-granted with a full frame.
REQ-034 Assert rst mid-frame: outputs take their reset values immediately, asynchronously; after release, the first grant goes to A when both requests are high.
REQ-035 With DAC_SCHED_LDAC_EN defined: after a B frame, LDAC_n is low for exactly 1 cycle, in the first CS-high cycle; after an A frame, LDAC_n stays 1.
